// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - Mini SRC control unit opcodes, states and ALU codes
package control_unit_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_INCPC = 5'b11111;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [4:0] {
        S_T0   = 5'd0,
        S_T1   = 5'd1,
        S_T2   = 5'd2,
        S_T3   = 5'd3,
        S_T4   = 5'd4,
        S_T5   = 5'd5,
        S_T6   = 5'd6,
        S_T7   = 5'd7,
        S_HALT = 5'd8
    } state_e;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_ITYPE,
        C_LDI,
        C_LD,
        C_ST,
        C_BR,
        C_JR,
        C_NOP,
        C_HALT,
        C_ILL
    } op_class_e;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode to instruction class decode
module control_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class
);

    // Map opcode to the class that selects the execute step sequence
    always_comb begin
        op_class = C_ILL;
        if (opcode >= OP_ADD && opcode <= OP_ROL) begin
            op_class = C_RTYPE;
        end else if (opcode >= OP_ADDI && opcode <= OP_ORI) begin
            op_class = C_ITYPE;
        end else begin
            case (opcode)
                OP_LD:   op_class = C_LD;
                OP_LDI:  op_class = C_LDI;
                OP_ST:   op_class = C_ST;
                OP_BR:   op_class = C_BR;
                OP_JR:   op_class = C_JR;
                OP_NOP:  op_class = C_NOP;
                OP_HALT: op_class = C_HALT;
                default: op_class = C_ILL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Mini SRC control FSM (T0..T7 step sequencer)
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Pout,
    output logic        Pen,
    output logic        MARen,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Yen,
    output logic        Zen,
    output logic        ZLOout,
    output logic        Cout,
    output logic        ConIn,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_control,
    output logic        halted,
    output logic        illegal,
    output logic [4:0]  state
);

    state_e     state_q;
    state_e     state_d;
    logic [4:0] opcode_q;
    logic [4:0] dec_opcode;
    op_class_e  op_class;
    logic       unused_ir_bits;

    // IR is still being loaded during T2, so T2 decides nop/halt from the live opcode
    assign dec_opcode     = (state_q == S_T2) ? ir[31:27] : opcode_q;
    assign unused_ir_bits = ^ir[26:0];
    assign state          = state_q;

    control_decode u_decode (
        .opcode   (dec_opcode),
        .op_class (op_class)
    );

    // State register and opcode latch (opcode captured at the end of T2)
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_T0;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T2) begin
                opcode_q <= ir[31:27];
            end
        end
    end

    // Next-state and Moore strobe decode; T0 fetch strobes also gated by reset
    always_comb begin
        state_d     = state_q;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        Pout        = 1'b0;
        Pen         = 1'b0;
        MARen       = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Yen         = 1'b0;
        Zen         = 1'b0;
        ZLOout      = 1'b0;
        Cout        = 1'b0;
        ConIn       = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        alu_control = 5'b00000;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_T0: begin
                if (run && clr) begin
                    Pout        = 1'b1;
                    MARen       = 1'b1;
                    Zen         = 1'b1;
                    alu_control = ALU_INCPC;
                    state_d     = S_T1;
                end
            end
            S_T1: begin
                ZLOout = 1'b1;
                Pen    = 1'b1;
                Read   = 1'b1;
                MDRen  = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                MDROut = 1'b1;
                IRen   = 1'b1;
                case (op_class)
                    C_NOP:   state_d = S_T0;
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                state_d = S_T4;
                case (op_class)
                    C_RTYPE, C_ITYPE: begin
                        Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
                    end
                    C_BR: begin
                        Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
                    end
                    C_JR: begin
                        Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
                        state_d = S_T0;
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = S_T0;
                    end
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (op_class)
                    C_RTYPE: begin
                        Grc = 1'b1; Rout = 1'b1; Zen = 1'b1;
                        alu_control = opcode_q;
                    end
                    C_ITYPE: begin
                        Cout = 1'b1; Zen = 1'b1;
                        alu_control = opcode_q;
                    end
                    C_LDI, C_LD, C_ST: begin
                        Cout = 1'b1; Zen = 1'b1;
                        alu_control = ALU_ADD;
                    end
                    C_BR: begin
                        Pout = 1'b1; Yen = 1'b1;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                state_d = S_T0;
                case (op_class)
                    C_RTYPE, C_ITYPE, C_LDI: begin
                        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ZLOout = 1'b1; MARen = 1'b1;
                        state_d = S_T6;
                    end
                    C_BR: begin
                        Cout = 1'b1; Zen = 1'b1;
                        alu_control = ALU_ADD;
                        state_d = S_T6;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T6: begin
                state_d = S_T0;
                case (op_class)
                    C_LD: begin
                        Read = 1'b1; MDRen = 1'b1;
                        state_d = mem_ready ? S_T7 : S_T6;
                    end
                    C_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
                        state_d = S_T7;
                    end
                    C_BR: begin
                        ZLOout = 1'b1;
                        Pen    = con_ff;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T7: begin
                state_d = S_T0;
                case (op_class)
                    C_LD: begin
                        MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    C_ST: begin
                        Write = 1'b1;
                        state_d = mem_ready ? S_T0 : S_T7;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_T0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven bench for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, run, con_ff, mem_ready;
    logic [31:0] ir;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Pout, Pen, MARen, MDRen, MDROut;
    logic        IRen, Yen, Zen, ZLOout, Cout, ConIn, Read, Write, halted, illegal;
    logic [4:0]  alu_control, state;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Pout(Pout), .Pen(Pen), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut),
        .IRen(IRen), .Yen(Yen), .Zen(Zen), .ZLOout(ZLOout), .Cout(Cout), .ConIn(ConIn),
        .Read(Read), .Write(Write), .alu_control(alu_control), .halted(halted),
        .illegal(illegal), .state(state)
    );

    localparam logic [20:0] M_GRA = 21'd1 << 0,  M_GRB = 21'd1 << 1,  M_GRC = 21'd1 << 2;
    localparam logic [20:0] M_RIN = 21'd1 << 3,  M_ROUT = 21'd1 << 4, M_BAOUT = 21'd1 << 5;
    localparam logic [20:0] M_POUT = 21'd1 << 6, M_PEN = 21'd1 << 7,  M_MAREN = 21'd1 << 8;
    localparam logic [20:0] M_MDREN = 21'd1 << 9, M_MDROUT = 21'd1 << 10, M_IREN = 21'd1 << 11;
    localparam logic [20:0] M_YEN = 21'd1 << 12, M_ZEN = 21'd1 << 13, M_ZLO = 21'd1 << 14;
    localparam logic [20:0] M_COUT = 21'd1 << 15, M_CONIN = 21'd1 << 16, M_READ = 21'd1 << 17;
    localparam logic [20:0] M_WRITE = 21'd1 << 18, M_HALTED = 21'd1 << 19, M_ILL = 21'd1 << 20;

    localparam logic [4:0] INC = 5'b11111, ADD = 5'b00011;

    localparam logic [31:0] I_ADD  = 32'h18918000;
    localparam logic [31:0] I_ROL  = 32'h50000000;
    localparam logic [31:0] I_ADDI = 32'h58000000;
    localparam logic [31:0] I_LDI  = 32'h08000000;
    localparam logic [31:0] I_LD   = 32'h00000000;
    localparam logic [31:0] I_ST   = 32'h10000000;
    localparam logic [31:0] I_BR   = 32'h90000000;
    localparam logic [31:0] I_JR   = 32'h98000000;
    localparam logic [31:0] I_NOP  = 32'hC8000000;
    localparam logic [31:0] I_HALT = 32'hD0000000;
    localparam logic [31:0] I_BAD  = 32'hD8000000;

    wire [20:0] sb_act = {illegal, halted, Write, Read, ConIn, Cout, ZLOout, Zen, Yen, IRen,
                          MDROut, MDRen, MARen, Pen, Pout, BAout, Rout, Rin, Grc, Grb, Gra};

    typedef struct {
        logic        run;
        logic [31:0] ir;
        logic        con;
        logic        mr;
        logic [4:0]  st;
        logic [20:0] sb;
        logic [4:0]  alu;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [31:0] i, input logic c, input logic m,
                        input logic [4:0] s, input logic [20:0] sb, input logic [4:0] a);
        vec_t v;
        v.run = r; v.ir = i; v.con = c; v.mr = m; v.st = s; v.sb = sb; v.alu = a;
        vq.push_back(v);
    endtask

    task automatic push_fetch(input logic [31:0] i, input int nwait);
        push(1'b1, i, 1'b0, 1'b1, 5'd0, M_POUT | M_MAREN | M_ZEN, INC);
        for (int k = 0; k < nwait; k++)
            push(1'b0, i, 1'b0, 1'b0, 5'd1, M_ZLO | M_PEN | M_READ | M_MDREN, 5'd0);
        push(1'b0, i, 1'b0, 1'b1, 5'd1, M_ZLO | M_PEN | M_READ | M_MDREN, 5'd0);
        push(1'b0, i, 1'b0, 1'b0, 5'd2, M_MDROUT | M_IREN, 5'd0);
    endtask

    task automatic push_idle(input logic [31:0] i);
        push(1'b0, i, 1'b0, 1'b1, 5'd0, 21'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input string name, input logic [4:0] s, input logic [20:0] sb, input logic [4:0] a);
        chk({name, "_state"}, 0, {27'd0, state}, {27'd0, s});
        chk({name, "_strobes"}, 0, {11'd0, sb_act}, {11'd0, sb});
        chk({name, "_alu"}, 0, {27'd0, alu_control}, {27'd0, a});
    endtask

    initial begin
        // add R1,R2,R3
        push_fetch(I_ADD, 0);
        push(0, I_ADD, 0, 0, 5'd3, M_GRB | M_ROUT | M_YEN, 5'd0);
        push(0, I_ADD, 0, 0, 5'd4, M_GRC | M_ROUT | M_ZEN, 5'b00011);
        push(0, I_ADD, 0, 0, 5'd5, M_ZLO | M_GRA | M_RIN, 5'd0);
        push_idle(I_ADD);
        // nop with three T1 wait states
        push_fetch(I_NOP, 3);
        push_idle(I_NOP);
        // rol: top of the R-type range
        push_fetch(I_ROL, 0);
        push(0, I_ROL, 0, 0, 5'd3, M_GRB | M_ROUT | M_YEN, 5'd0);
        push(0, I_ROL, 0, 0, 5'd4, M_GRC | M_ROUT | M_ZEN, 5'b01010);
        push(0, I_ROL, 0, 0, 5'd5, M_ZLO | M_GRA | M_RIN, 5'd0);
        push_idle(I_ROL);
        // addi
        push_fetch(I_ADDI, 0);
        push(0, I_ADDI, 0, 0, 5'd3, M_GRB | M_ROUT | M_YEN, 5'd0);
        push(0, I_ADDI, 0, 0, 5'd4, M_COUT | M_ZEN, 5'b01011);
        push(0, I_ADDI, 0, 0, 5'd5, M_ZLO | M_GRA | M_RIN, 5'd0);
        push_idle(I_ADDI);
        // ldi
        push_fetch(I_LDI, 0);
        push(0, I_LDI, 0, 0, 5'd3, M_GRB | M_BAOUT | M_YEN, 5'd0);
        push(0, I_LDI, 0, 0, 5'd4, M_COUT | M_ZEN, ADD);
        push(0, I_LDI, 0, 0, 5'd5, M_ZLO | M_GRA | M_RIN, 5'd0);
        push_idle(I_LDI);
        // br taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            push_fetch(I_BR, 0);
            push(0, I_BR, t[0], 0, 5'd3, M_GRA | M_ROUT | M_CONIN, 5'd0);
            push(0, I_BR, t[0], 0, 5'd4, M_POUT | M_YEN, 5'd0);
            push(0, I_BR, t[0], 0, 5'd5, M_COUT | M_ZEN, ADD);
            push(0, I_BR, t[0], 0, 5'd6, t[0] ? (M_ZLO | M_PEN) : M_ZLO, 5'd0);
            push_idle(I_BR);
        end
        // ld with two T6 wait states
        push_fetch(I_LD, 0);
        push(0, I_LD, 0, 0, 5'd3, M_GRB | M_BAOUT | M_YEN, 5'd0);
        push(0, I_LD, 0, 0, 5'd4, M_COUT | M_ZEN, ADD);
        push(0, I_LD, 0, 0, 5'd5, M_ZLO | M_MAREN, 5'd0);
        push(0, I_LD, 0, 0, 5'd6, M_READ | M_MDREN, 5'd0);
        push(0, I_LD, 0, 0, 5'd6, M_READ | M_MDREN, 5'd0);
        push(0, I_LD, 0, 1, 5'd6, M_READ | M_MDREN, 5'd0);
        push(0, I_LD, 0, 0, 5'd7, M_MDROUT | M_GRA | M_RIN, 5'd0);
        push_idle(I_LD);
        // st with two T7 wait states; mem_ready high in T6 must not matter
        push_fetch(I_ST, 0);
        push(0, I_ST, 0, 0, 5'd3, M_GRB | M_BAOUT | M_YEN, 5'd0);
        push(0, I_ST, 0, 0, 5'd4, M_COUT | M_ZEN, ADD);
        push(0, I_ST, 0, 0, 5'd5, M_ZLO | M_MAREN, 5'd0);
        push(0, I_ST, 0, 1, 5'd6, M_GRA | M_ROUT | M_MDREN, 5'd0);
        push(0, I_ST, 0, 0, 5'd7, M_WRITE, 5'd0);
        push(0, I_ST, 0, 0, 5'd7, M_WRITE, 5'd0);
        push(0, I_ST, 0, 1, 5'd7, M_WRITE, 5'd0);
        push_idle(I_ST);
        // jr
        push_fetch(I_JR, 0);
        push(0, I_JR, 0, 0, 5'd3, M_GRA | M_ROUT | M_PEN, 5'd0);
        push_idle(I_JR);
        // unsupported opcode 11011, then fetch resumes
        push_fetch(I_BAD, 0);
        push(0, I_BAD, 0, 0, 5'd3, M_ILL, 5'd0);
        push_fetch(I_NOP, 0);
        push_idle(I_NOP);

        // reset state, with run high to show reset wins
        clr = 1'b0; run = 1'b1; ir = I_ADD; con_ff = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk_now("reset", 5'd0, 21'd0, 5'd0);
        step();
        clr = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run = vq[i].run; ir = vq[i].ir; con_ff = vq[i].con; mem_ready = vq[i].mr;
            @(negedge clk);
            chk("state", i, {27'd0, state}, {27'd0, vq[i].st});
            chk("strobes", i, {11'd0, sb_act}, {11'd0, vq[i].sb});
            chk("alu", i, {27'd0, alu_control}, {27'd0, vq[i].alu});
            chk("rw_excl", i, {31'd0, Read & Write}, 32'd0);
            step();
        end

        // asynchronous reset in the middle of a stalled st T7
        run = 1'b1; ir = I_ST; con_ff = 1'b0; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk_now("st_t7", 5'd7, M_WRITE, 5'd0);
        step();
        #2 clr = 1'b0;
        #1 chk_now("abort_now", 5'd0, 21'd0, 5'd0);
        @(negedge clk);
        chk_now("abort_hold", 5'd0, 21'd0, 5'd0);
        step();
        clr = 1'b1; run = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk_now("after_abort", 5'd0, 21'd0, 5'd0);
        step();

        // halt: stays put with run high
        run = 1'b1; ir = I_HALT;
        repeat (3) step();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_state", k, {27'd0, state}, 32'd8);
            chk("halt_strobes", k, {11'd0, sb_act}, {11'd0, M_HALTED});
            step();
        end
        #2 clr = 1'b0;
        #1 chk_now("halt_reset", 5'd0, 21'd0, 5'd0);
        step();
        clr = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
